// File: rtl/t03_timer_pkg.sv
// Shared types and constants for the t03 hardware timer.
package t03_timer_pkg;

    typedef enum logic {
        TMR_ONESHOT  = 1'b0,
        TMR_PERIODIC = 1'b1
    } tmr_mode_t;

    // Divisor loaded at reset: one tick every DIV_DEFAULT+1 clocks.
    localparam int DIV_DEFAULT = 10000;

endpackage

// File: rtl/t03_prescaler.sv
// Runtime-programmable clock prescaler. Emits a one-cycle strobe on the
// clock in which the internal count reaches the divisor, so the owner can
// advance its counter on that same edge.
module t03_prescaler
    import t03_timer_pkg::*;
#(
    parameter int PW        = 16,
    parameter int DIV_RESET = DIV_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          div_wr,
    input  logic [PW-1:0] div_in,
    output logic          tick_pulse
);

    logic [PW-1:0] pcount_q, pcount_d;
    logic [PW-1:0] div_q, div_d;

    // Next-state: clr beats a divisor write, which beats normal counting.
    always_comb begin
        // NOTE: every output of a combinational block is assigned a default
        // first so that no path leaves it unassigned and infers a latch.
        pcount_d   = pcount_q;
        div_d      = div_q;
        tick_pulse = 1'b0;
        if (clr) begin
            pcount_d = '0;
        end else if (div_wr) begin
            div_d    = div_in;
            pcount_d = '0;
        end else if (en) begin
            if (pcount_q == div_q) begin
                pcount_d   = '0;
                tick_pulse = 1'b1;
            end else begin
                pcount_d = pcount_q + 1'b1;
            end
        end
    end

    // State register with synchronous reset to the default divisor.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            pcount_q <= '0;
            div_q    <= PW'(DIV_RESET);
        end else begin
            pcount_q <= pcount_d;
            div_q    <= div_d;
        end
    end

endmodule

// File: rtl/t03_hw_timer.sv
// System timebase: prescaled free-running tick counter plus NCH compare
// channels (one-shot or periodic) that raise sticky interrupt flags.
module t03_hw_timer
    import t03_timer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PW        = 16,
    parameter int NCH       = 4,
    parameter int DIV_RESET = DIV_DEFAULT,
    localparam int SW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             div_wr,
    input  logic [PW-1:0]    div_in,
    input  logic             cfg_wr,
    input  logic [SW-1:0]    cfg_sel,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_periodic,
    input  logic             cfg_disarm,
    input  logic [NCH-1:0]   irq_clr,
    output logic [WIDTH-1:0] counter,
    output logic             tick,
    output logic             overflow,
    output logic [NCH-1:0]   irq,
    output logic [NCH-1:0]   armed
);

    logic             tick_pulse;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic             tick_q, tick_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] period_eff;

    t03_prescaler #(
        .PW        (PW),
        .DIV_RESET (DIV_RESET)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .div_wr     (div_wr),
        .div_in     (div_in),
        .tick_pulse (tick_pulse)
    );

    // Counter next value; the prescaler never strobes during clr or div_wr.
    always_comb begin
        counter_d  = counter_q;
        tick_d     = tick_pulse;
        overflow_d = 1'b0;
        period_eff = (cfg_period == '0) ? WIDTH'(1) : cfg_period;
        if (clr) begin
            counter_d = '0;
        end else if (tick_pulse) begin
            counter_d  = counter_q + 1'b1;
            overflow_d = (counter_q == '1);
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q  <= '0;
            tick_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            counter_q  <= counter_d;
            tick_q     <= tick_d;
            overflow_q <= overflow_d;
        end
    end

    assign counter  = counter_q;
    assign tick     = tick_q;
    assign overflow = overflow_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] cmp_q, cmp_d;
        logic [WIDTH-1:0] period_q, period_d;
        tmr_mode_t        mode_q, mode_d;
        logic             armed_q, armed_d;
        logic             irq_q, irq_d;
        logic             sel_hit;
        logic             match;

        // Channel next-state: a config write to this channel overrides a match.
        always_comb begin
            cmp_d    = cmp_q;
            period_d = period_q;
            mode_d   = mode_q;
            armed_d  = armed_q;
            sel_hit  = cfg_wr && (cfg_sel == SW'(i));
            match    = tick_pulse && armed_q && (counter_d == cmp_q);
            if (sel_hit) begin
                if (cfg_disarm) begin
                    armed_d = 1'b0;
                end else begin
                    cmp_d    = counter_d + period_eff;
                    period_d = period_eff;
                    mode_d   = cfg_periodic ? TMR_PERIODIC : TMR_ONESHOT;
                    armed_d  = 1'b1;
                end
            end else if (match) begin
                if (mode_q == TMR_PERIODIC) begin
                    cmp_d = cmp_q + period_q;
                end else begin
                    armed_d = 1'b0;
                end
            end
            // Set beats write-1-to-clear so a match is never lost.
            irq_d = (irq_q && !irq_clr[i]) || (match && !sel_hit);
        end

        // Channel registers.
        always_ff @(posedge clk) begin
            // NOTE: the compare/period registers are reset along with the
            // flags so a reset leaves no stale match target behind.
            if (rst) begin
                cmp_q    <= '0;
                period_q <= '0;
                mode_q   <= TMR_ONESHOT;
                armed_q  <= 1'b0;
                irq_q    <= 1'b0;
            end else begin
                cmp_q    <= cmp_d;
                period_q <= period_d;
                mode_q   <= mode_d;
                armed_q  <= armed_d;
                irq_q    <= irq_d;
            end
        end

        assign irq[i]   = irq_q;
        assign armed[i] = armed_q;
    end

endmodule

// File: tb/tb_t03_hw_timer.sv
// Randomised scoreboard bench for t03_hw_timer (8-bit counter build).
module tb_t03_hw_timer;

    localparam int WIDTH = 8;
    localparam int PW    = 16;
    localparam int NCH   = 4;
    localparam int MODV  = 256;

    logic             clk = 1'b0;
    logic             rst, en, clr, div_wr;
    logic [PW-1:0]    div_in;
    logic             cfg_wr;
    logic [1:0]       cfg_sel;
    logic [WIDTH-1:0] cfg_period;
    logic             cfg_periodic, cfg_disarm;
    logic [NCH-1:0]   irq_clr;
    logic [WIDTH-1:0] counter;
    logic             tick, overflow;
    logic [NCH-1:0]   irq, armed;

    int n_cmp = 0;
    int n_err = 0;

    t03_hw_timer #(
        .WIDTH     (WIDTH),
        .PW        (PW),
        .NCH       (NCH),
        .DIV_RESET (10000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .clr          (clr),
        .div_wr       (div_wr),
        .div_in       (div_in),
        .cfg_wr       (cfg_wr),
        .cfg_sel      (cfg_sel),
        .cfg_period   (cfg_period),
        .cfg_periodic (cfg_periodic),
        .cfg_disarm   (cfg_disarm),
        .irq_clr      (irq_clr),
        .counter      (counter),
        .tick         (tick),
        .overflow     (overflow),
        .irq          (irq),
        .armed        (armed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst, en, clr, div_wr;
        logic [PW-1:0]    div_in;
        logic             cfg_wr;
        logic [1:0]       sel;
        logic [WIDTH-1:0] period;
        logic             periodic, disarm;
        logic [NCH-1:0]   irq_clr;
    } stim_t;

    typedef struct {
        logic [WIDTH-1:0] counter;
        logic             tick, overflow;
        logic [NCH-1:0]   irq, armed;
    } exp_t;

    exp_t sb_q[$];

    // Behavioural reference: plain integers, rules applied in priority order.
    int m_count, m_pcount, m_div;
    int m_cmp[NCH], m_per[NCH];
    bit m_periodic[NCH], m_armed[NCH], m_irq[NCH];
    bit run_en;

    task automatic model(input stim_t s);
        exp_t e;
        bit   t, ov;
        int   p;
        t  = 0;
        ov = 0;
        if (s.rst) begin
            m_count = 0; m_pcount = 0; m_div = 10000;
            for (int i = 0; i < NCH; i++) begin
                m_cmp[i] = 0; m_per[i] = 0; m_periodic[i] = 0;
                m_armed[i] = 0; m_irq[i] = 0;
            end
        end else begin
            if (s.clr) begin
                m_count = 0; m_pcount = 0;
            end else if (s.div_wr) begin
                m_div = int'(s.div_in); m_pcount = 0;
            end else if (s.en) begin
                if (m_pcount == m_div) begin
                    m_pcount = 0; t = 1;
                end else begin
                    m_pcount++;
                end
            end
            if (t) begin
                m_count = (m_count + 1) % MODV;
                ov = (m_count == 0);
            end
            for (int i = 0; i < NCH; i++) begin
                bit hit;
                hit = 0;
                if (s.cfg_wr && int'(s.sel) == i) begin
                    if (s.disarm) begin
                        m_armed[i] = 0;
                    end else begin
                        p = (s.period == 0) ? 1 : int'(s.period);
                        m_cmp[i] = (m_count + p) % MODV;
                        m_per[i] = p;
                        m_periodic[i] = s.periodic;
                        m_armed[i] = 1;
                    end
                end else if (t && m_armed[i] && m_count == m_cmp[i]) begin
                    hit = 1;
                    if (m_periodic[i]) m_cmp[i] = (m_cmp[i] + m_per[i]) % MODV;
                    else               m_armed[i] = 0;
                end
                m_irq[i] = hit || (m_irq[i] && !s.irq_clr[i]);
            end
        end
        e.counter  = WIDTH'(m_count);
        e.tick     = t;
        e.overflow = ov;
        for (int i = 0; i < NCH; i++) begin
            e.irq[i]   = m_irq[i];
            e.armed[i] = m_armed[i];
        end
        sb_q.push_back(e);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.en = run_en;
        return s;
    endfunction

    // Drive one clock's inputs at the falling edge and queue the expectation.
    task automatic step(input stim_t s);
        @(negedge clk);
        rst = s.rst; en = s.en; clr = s.clr; div_wr = s.div_wr; div_in = s.div_in;
        cfg_wr = s.cfg_wr; cfg_sel = s.sel; cfg_period = s.period;
        cfg_periodic = s.periodic; cfg_disarm = s.disarm; irq_clr = s.irq_clr;
        model(s);
    endtask

    task automatic arm(input int ch, input int per, input bit periodic);
        stim_t s;
        s = idle();
        s.cfg_wr = 1; s.sel = 2'(ch); s.period = WIDTH'(per); s.periodic = periodic;
        step(s);
    endtask

    task automatic set_div(input int d);
        stim_t s;
        s = idle();
        s.div_wr = 1; s.div_in = PW'(d);
        step(s);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: compare DUT outputs shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (counter !== e.counter || tick !== e.tick || overflow !== e.overflow ||
                    irq !== e.irq || armed !== e.armed) begin
                    n_err++;
                    $display("FAIL cycle t=%0t: got cnt=%0d tick=%b ovf=%b irq=%b armed=%b, expected cnt=%0d tick=%b ovf=%b irq=%b armed=%b",
                             $time, counter, tick, overflow, irq, armed,
                             e.counter, e.tick, e.overflow, e.irq, e.armed);
                end
            end
        end
    end

    initial begin
        stim_t s;
        run_en = 0;
        rst = 1; en = 0; clr = 0; div_wr = 0; div_in = '0; cfg_wr = 0; cfg_sel = '0;
        cfg_period = '0; cfg_periodic = 0; cfg_disarm = 0; irq_clr = '0;

        // Reset, then default divisor: three ticks in 30003 enabled clocks.
        s = idle(); s.rst = 1;
        step(s); step(s);
        run_en = 1;
        repeat (30003) step(idle());
        @(posedge clk); #3;
        check("default_div_counter", 32'(counter), 32'd3);

        // Divisor 3, then divisor 0.
        set_div(3);
        repeat (40) step(idle());
        set_div(0);
        repeat (20) step(idle());

        // One-shot on ch0, clear, then run past a full wrap.
        arm(0, 5, 0);
        repeat (10) step(idle());
        s = idle(); s.irq_clr = 4'b0001; step(s);
        repeat (300) step(idle());

        // Periodic ch1 across wraps, clearing its flag each time it is seen set.
        arm(1, 100, 1);
        repeat (700) begin
            s = idle();
            if (m_irq[1]) s.irq_clr = 4'b0010;
            step(s);
        end

        // irq_clr[2] on the same edge as ch2's match.
        arm(2, 3, 0);
        repeat (2) step(idle());
        s = idle(); s.irq_clr = 4'b0100; step(s);
        step(idle());
        // Re-arm ch3 on the edge where it would match.
        arm(3, 4, 1);
        repeat (3) step(idle());
        arm(3, 10, 1);
        repeat (15) step(idle());
        // clr on the cycle a tick is due.
        set_div(2);
        repeat (2) step(idle());
        s = idle(); s.clr = 1; step(s);
        repeat (6) step(idle());

        // Random mix.
        repeat (3000) begin
            run_en = ($urandom_range(7) != 0);
            s = idle();
            s.clr = ($urandom_range(63) == 0);
            if ($urandom_range(49) == 0) begin
                s.div_wr = 1; s.div_in = PW'($urandom_range(3));
            end
            if ($urandom_range(5) == 0) begin
                s.cfg_wr = 1; s.sel = 2'($urandom_range(3));
                s.period = WIDTH'($urandom_range(11));
                s.periodic = 1'($urandom_range(1));
                s.disarm = ($urandom_range(7) == 0);
            end
            if ($urandom_range(3) == 0) s.irq_clr = 4'($urandom);
            s.rst = ($urandom_range(999) == 0);
            step(s);
        end

        // Mid-operation reset with live state; divisor must return to default.
        run_en = 1;
        set_div(0);
        arm(0, 2, 1); arm(1, 3, 0); arm(2, 1, 0); arm(3, 200, 0);
        repeat (4) step(idle());
        s = idle(); s.rst = 1; step(s);
        @(posedge clk); #3;
        check("mid_reset_irq", 32'(irq), 32'd0);
        repeat (10005) step(idle());

        repeat (3) @(posedge clk);
        #3;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
